mem_access_stage: RTL



---
 rtl/mem_stage_pkg.sv | 42 ++++
 rtl/mem_lane_align.sv | 44 ++++
 rtl/mem_access_stage.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_pkg
// Purpose  : Shared types and helpers for the MEM-stage controller.
//            FSM state encoding, load funct3 codes and the load
//            alignment/extension function.
// Revision : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Bring the addressed byte lane down to bit 0, then sign/zero extend.
  // Bytes that fall off the top of the word read back as zero.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  off,
                                              input logic [2:0]  funct3);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (funct3)
      F3_LB:   load_extend = {{24{sh[7]}}, sh[7:0]};
      F3_LH:   load_extend = {{16{sh[15]}}, sh[15:0]};
      F3_LW:   load_extend = sh;
      F3_LBU:  load_extend = {24'h0, sh[7:0]};
      F3_LHU:  load_extend = {16'h0, sh[15:0]};
      default: load_extend = sh;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : mem_lane_align
// Purpose  : Combinational byte-lane steering for the MEM stage.
//            Store side: shifts write data and rotates the bit mask into
//            byte strobes. Load side: extracts and extends the load result.
// Ports    : st_off_i/st_data_i/st_mask_i -> wdata_o/wstrb_o
//            ld_off_i/ld_funct3_i/ld_word_i -> ld_data_o
// Revision : 1.0 - initial release
// ============================================================================
module mem_lane_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_data_i,
  input  logic [31:0] st_mask_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  input  logic [1:0]  ld_off_i,
  input  logic [2:0]  ld_funct3_i,
  input  logic [31:0] ld_word_i,
  output logic [31:0] ld_data_o
);

  logic [4:0]  sh;
  logic [63:0] mask2;
  logic [31:0] rot_mask;

  always_comb begin
    sh       = {st_off_i, 3'b000};
    // Data bytes shifted past bit 31 are dropped.
    wdata_o  = st_data_i << sh;
    // Upper half of the doubled mask after a left shift is a left rotate.
    mask2    = {st_mask_i, st_mask_i} << sh;
    rot_mask = mask2[63:32];
    wstrb_o  = 4'h0;
    for (int i = 0; i < 4; i++) begin
      wstrb_o[i] = |rot_mask[8*i +: 8];
    end
    ld_data_o = load_extend(ld_word_i, ld_off_i, ld_funct3_i);
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_stage
// Purpose  : MEM-stage controller between EX/MEM and MEM/WB. Issues one
//            valid/ready request per load/store to the data-memory bridge,
//            stalls the CPU while the access is outstanding and returns
//            aligned, extended load data.
// Ports    : alu_in/dm_in/wmask_in/mem_read_in/mem_write_in/instr_in from
//            EX/MEM; ext_stall_in; mem_stall_out/load_data_out/misalign_out
//            to the pipeline; dm_req_* / dm_addr / dm_wdata / dm_wstrb and
//            dm_rsp_* towards data memory.
// Options  : MISALIGN_TRAP_EN - suppress misaligned half/word accesses and
//            flag them on misalign_out instead of issuing them.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] alu_in,
  input  logic [DATA_W-1:0] dm_in,
  input  logic [DATA_W-1:0] wmask_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic [31:0]       instr_in,
  input  logic              ext_stall_in,
  output logic              mem_stall_out,
  output logic [DATA_W-1:0] load_data_out,
  output logic              misalign_out,
  output logic              dm_req_valid,
  input  logic              dm_req_ready,
  output logic              dm_req_write,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  output logic [3:0]        dm_wstrb,
  input  logic              dm_rsp_valid,
  input  logic [DATA_W-1:0] dm_rsp_rdata
);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          wstrb_q, wstrb_d;
  logic                write_q, write_d;
  logic [1:0]          off_q, off_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [31:0]         load_q, load_d;
  logic                misalign_q, misalign_d;

  logic                w_op;
  logic                w_misalign;
  logic [31:0]         w_wdata;
  logic [3:0]          w_wstrb;
  logic [31:0]         w_load;

  logic                unused_instr_bits;
  assign unused_instr_bits = ^{instr_in[31:15], instr_in[11:0]};

  assign w_op = mem_read_in | mem_write_in;

  // Store lanes come from the live EX/MEM fields (latched on issue);
  // load extraction uses the offset/funct3 captured with the request.
  mem_lane_align u_lane (
    .st_off_i    (alu_in[1:0]),
    .st_data_i   (dm_in),
    .st_mask_i   (wmask_in),
    .wdata_o     (w_wdata),
    .wstrb_o     (w_wstrb),
    .ld_off_i    (off_q),
    .ld_funct3_i (funct3_q),
    .ld_word_i   (dm_rsp_rdata),
    .ld_data_o   (w_load)
  );

`ifdef MISALIGN_TRAP_EN
  always_comb begin
    case (instr_in[13:12])
      2'b01:   w_misalign = alu_in[0];
      2'b10:   w_misalign = |alu_in[1:0];
      default: w_misalign = 1'b0;
    endcase
  end
`else
  // Misaligned accesses are issued word-aligned; misalign_q stays 0.
  assign w_misalign = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    write_d       = write_q;
    off_d         = off_q;
    funct3_d      = funct3_q;
    load_d        = load_q;
    misalign_d    = misalign_q;
    mem_stall_out = 1'b0;
    dm_req_valid  = 1'b0;

    case (state_q)
      IDLE: begin
        mem_stall_out = w_op;
        if (w_op) begin
          addr_d   = {alu_in[ADDR_W-1:2], 2'b00};
          wdata_d  = w_wdata;
          wstrb_d  = w_wstrb;
          write_d  = mem_write_in;
          off_d    = alu_in[1:0];
          funct3_d = instr_in[14:12];
          if (w_misalign) begin
            misalign_d = 1'b1;
            load_d     = 32'h0;
            state_d    = DONE;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        mem_stall_out = 1'b1;
        dm_req_valid  = 1'b1;
        if (dm_req_ready) begin
          if (dm_rsp_valid) begin
            if (!write_q) load_d = w_load;
            state_d = DONE;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        mem_stall_out = 1'b1;
        if (dm_rsp_valid) begin
          if (!write_q) load_d = w_load;
          state_d = DONE;
        end
      end
      DONE: begin
        // Holding here while stalled keeps the still-present op from
        // being seen again in IDLE.
        if (!ext_stall_in) begin
          misalign_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= 32'h0;
      wstrb_q    <= 4'h0;
      write_q    <= 1'b0;
      off_q      <= 2'b00;
      funct3_q   <= 3'b000;
      load_q     <= 32'h0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      write_q    <= write_d;
      off_q      <= off_d;
      funct3_q   <= funct3_d;
      load_q     <= load_d;
      misalign_q <= misalign_d;
    end
  end

  assign dm_addr       = addr_q;
  assign dm_wdata      = wdata_q;
  assign dm_wstrb      = wstrb_q;
  assign dm_req_write  = write_q;
  assign load_data_out = load_q;
  assign misalign_out  = misalign_q;

endmodule
`default_nettype wire
